mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the shared single-port Memory block (16-bit write-enable, address, write-data, read-out). Port 0 is instruction fetch and port 1 is load/store. Each transaction runs through a fixed IDLE→ACCESS→DONE sequence with round-robin grant. The block sits between the CPU front-end/LSU and Memory, and is the only driver of Memory's inputs.

Parameters:
DATA_W, 16, width of data and Memory read-out
ADDR_W, 16, address width passed through to Memory
ACCESS_CYCLES, 1, cycles Memory inputs are held per access (≥1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
req0  in  1  port 0 request; held until ack0
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 completion, one-cycle pulse
rdata0  out  DATA_W  port 0 read data
req1, we1, addr1, wdata1, ack1, rdata1  as port 0, for port 1
mem_w  out  16  Memory write enable (16'h0001 = write, 16'h0000 = no write)
mem_a  out  ADDR_W  Memory address
mem_d  out  DATA_W  Memory write data
mem_out  in  DATA_W  Memory read data (combinational from mem_a)
busy  out  1  high when state ≠ IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, mem_w=0, mem_a=0, mem_d=0, ack0=ack1=0, rdata0=rdata1=0, busy=0, cnt=0, last_grant=1 (port 0 wins first tie). All outputs are registered.
- IDLE: mem_w=0. If any req is high at the edge: pick a winner, latch its we/addr/wdata and winner id, cnt←0, go ACCESS. Otherwise stay.
- Pick rule: only one req high → that port. Both high → port ≠ last_grant.
- ACCESS: mem_a=latched addr, mem_d=latched wdata, mem_w=16'h0001 if latched we else 0. Held exactly ACCESS_CYCLES cycles; cnt increments each cycle. At the edge ending the last cycle:
  - for a read, capture mem_out into the winner's rdata;
  - set mem_w←0, last_grant←winner, go DONE.
- DONE: winner's ack=1 for exactly one cycle, busy=1; next edge → IDLE. mem_a and mem_d keep their last values; mem_w=0.
- Latency: req sampled at edge E → ack high during cycle E+ACCESS_CYCLES+1. Throughput: one transaction per ACCESS_CYCLES+2 cycles.
- Requester contract: addr/we/wdata are stable while req is high. Req is dropped, or changed to a new request, in the cycle after ack.
- rdata holds its value until that port's next completed read. Writes never change rdata.
- Inputs changing during ACCESS have no effect (latched copy drives Memory).
- A req dropped mid-transaction does not abort it: the access completes and ack still pulses.
- Both ports continuously requesting → strict alternation 0,1,0,1…
- Reset mid-ACCESS: mem_w falls immediately, no ack is issued, and a partial write may have occurred. After release, arbitration restarts from IDLE with port 0 priority.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2
  - PORT_FETCH=0, PORT_LSU=1
  - MEM_WE_ON=16'h0001, MEM_WE_OFF=16'h0000
- One sub-module: rr_pick2, combinational two-way round-robin picker (inputs: req0, req1, last_grant; outputs: valid, winner). The FSM, counter and latches stay in mem_arbiter.

Test Plan:
1. Reset: hold rst_n=0 mid-cycle → all outputs 0 without a clock edge. Release with no req for 10 cycles → mem_w=0, busy=0 throughout.
2. ACCESS_CYCLES=1, port0 write a=4 d=6, then port0 read a=4 → mem_w=16'h0001 for exactly 1 cycle; each ack 2 cycles after its sampling edge; rdata0=6.
3. Both req in the same cycle after reset: port0 write a=3 d=7, port1 read a=3 → port0 served first, ack1 exactly 3 cycles after ack0, rdata1=7.
4. Both ports hold reads (a=0 and a=8, preloaded 5 and 8) for 6 transactions → ack order 0,1,0,1,0,1; rdata0=5, rdata1=8.
5. ACCESS_CYCLES=3: read latency 4 cycles; write holds mem_w high exactly 3 cycles; changing addr0 during ACCESS does not change mem_a.
6. Assert rst_n=0 during ACCESS of a write (a=5 d=9) → mem_w drops immediately, no ack. After release, simultaneous reqs → port0 granted first.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port ids and the Memory write-enable codes.
// Pure declarations; no logic, no latency, no flow control.

package mem_arb_pkg;

    // Transaction sequencer states. Every access walks IDLE -> ACCESS -> DONE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Requester ids as seen by the picker and the grant history.
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    // Memory takes a full 16-bit write-enable word; only these two values are legal.
    localparam logic [15:0] MEM_WE_ON  = 16'h0001;
    localparam logic [15:0] MEM_WE_OFF = 16'h0000;

    // Map a requester write flag onto the Memory write-enable word.
    function automatic logic [15:0] mem_we_code(input logic we);
        return we ? MEM_WE_ON : MEM_WE_OFF;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester handshakes plus the Memory-side bus.
// Latency: n/a (wires only).
// Backpressure: req is held until the matching one-cycle ack pulse.
//
// Ports (per requester n = 0,1):
//   reqn/wen/addrn/wdatan : requester -> arbiter, stable while reqn is high
//   ackn/rdatan           : arbiter -> requester, ack is a one-cycle pulse
// Memory side:
//   mem_w/mem_a/mem_d     : arbiter -> Memory (registered)
//   mem_out               : Memory -> arbiter, combinational from mem_a
//   busy                  : arbiter status, high whenever not idle

interface mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [15:0]       mem_w;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_out;

    logic              busy;

    // Arbiter side.
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_out,
        output ack0, rdata0,
        output ack1, rdata1,
        output mem_w, mem_a, mem_d,
        output busy
    );

    // Requester / Memory-model side.
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_out,
        input  ack0, rdata0,
        input  ack1, rdata1,
        input  mem_w, mem_a, mem_d,
        input  busy
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: chooses which pending request starts next.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only consumes the pick when it is idle.
//
// Ports:
//   i_req0, i_req1 : pending requests
//   i_last_grant   : port id of the most recently completed transaction
//   o_valid        : at least one request pending
//   o_winner       : chosen port id (meaningful only when o_valid)

module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_winner
);

    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = PORT_FETCH;
        if (i_req0 && i_req1) begin
            // Contention: the port that was not served last goes next.
            o_winner = ~i_last_grant;
        end else if (i_req1) begin
            o_winner = PORT_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer giving instruction fetch (port 0) and load/store (port 1)
// turns on the single-port Memory, one IDLE->ACCESS->DONE sequence per access.
// Latency: ack pulses ACCESS_CYCLES+1 edges after req is first seen while idle.
// Backpressure: a requester holds req until its ack; the loser keeps waiting.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : requester handshakes and the Memory bus (mem_arbiter_if.slave)
// ACCESS_CYCLES must be at least 1.

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 16,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    // Counter only needs to reach ACCESS_CYCLES-1; keep at least one bit.
    localparam int              CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_grant;
    logic               r_winner;
    logic               r_we;

    // Registered outputs. r_mem_a / r_mem_d double as the latched copy of
    // the winning request, so requester inputs are ignored once ACCESS starts.
    logic [15:0]        r_mem_w;
    logic [ADDR_W-1:0]  r_mem_a;
    logic [DATA_W-1:0]  r_mem_d;
    logic               r_ack0;
    logic               r_ack1;
    logic [DATA_W-1:0]  r_rdata0;
    logic [DATA_W-1:0]  r_rdata1;
    logic               r_busy;

    logic               w_valid;
    logic               w_winner;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;

    rr_pick2 u_pick (
        .i_req0       (bus.req0),
        .i_req1       (bus.req1),
        .i_last_grant (r_last_grant),
        .o_valid      (w_valid),
        .o_winner     (w_winner)
    );

    // Request fields of whichever port the picker chose.
    assign w_sel_we    = (w_winner == PORT_LSU) ? bus.we1    : bus.we0;
    assign w_sel_addr  = (w_winner == PORT_LSU) ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = (w_winner == PORT_LSU) ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            // Pretend port 1 was served last so port 0 wins the first tie.
            r_last_grant <= PORT_LSU;
            r_winner     <= PORT_FETCH;
            r_we         <= 1'b0;
            r_mem_w      <= MEM_WE_OFF;
            r_mem_a      <= '0;
            r_mem_d      <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mem_w <= MEM_WE_OFF;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    if (w_valid) begin
                        r_winner <= w_winner;
                        r_we     <= w_sel_we;
                        r_cnt    <= '0;
                        // Memory inputs are loaded here so they are valid for
                        // the whole first ACCESS cycle.
                        r_mem_a  <= w_sel_addr;
                        r_mem_d  <= w_sel_wdata;
                        r_mem_w  <= mem_we_code(w_sel_we);
                        r_busy   <= 1'b1;
                        r_state  <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        // mem_out is combinational from mem_a, which has been
                        // stable for the whole access, so it is settled here.
                        if (!r_we) begin
                            if (r_winner == PORT_LSU) begin
                                r_rdata1 <= bus.mem_out;
                            end else begin
                                r_rdata0 <= bus.mem_out;
                            end
                        end
                        r_mem_w      <= MEM_WE_OFF;
                        r_last_grant <= r_winner;
                        r_ack0       <= (r_winner == PORT_FETCH);
                        r_ack1       <= (r_winner == PORT_LSU);
                        r_state      <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // mem_a / mem_d intentionally keep their last values.
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_mem_w <= MEM_WE_OFF;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_w  = r_mem_w;
    assign bus.mem_a  = r_mem_a;
    assign bus.mem_d  = r_mem_d;
    assign bus.ack0   = r_ack0;
    assign bus.ack1   = r_ack1;
    assign bus.rdata0 = r_rdata0;
    assign bus.rdata1 = r_rdata1;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance A uses ACCESS_CYCLES=1, instance B uses 3.
// Expected acks (port, rdata, cycle) are queued at issue time; a negedge monitor pops them.
// Each instance has its own behavioural Memory written on posedge while mem_w is on.

module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int AC_A = 1;
    localparam int AC_B = 3;

    typedef struct {
        int          port;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    exp_t sbq_a[$];
    exp_t sbq_b[$];
    int   wrun [2];
    logic m_a0, m_a1;
    exp_t m_e;

    logic [15:0] mem_ma [256];
    logic [15:0] mem_mb [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ACCESS_CYCLES(AC_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ACCESS_CYCLES(AC_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Memory models: preload a[0]=5, a[8]=8 on the first edge, then write on mem_w.
    assign bus_a.mem_out = mem_ma[bus_a.mem_a[7:0]];
    assign bus_b.mem_out = mem_mb[bus_b.mem_a[7:0]];

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) begin
                mem_ma[i] <= 16'd0;
                mem_mb[i] <= 16'd0;
            end
            mem_ma[0] <= 16'd5; mem_ma[8] <= 16'd8;
            mem_mb[0] <= 16'd5; mem_mb[8] <= 16'd8;
        end else begin
            if (bus_a.mem_w === MEM_WE_ON) mem_ma[bus_a.mem_a[7:0]] <= bus_a.mem_d;
            if (bus_b.mem_w === MEM_WE_ON) mem_mb[bus_b.mem_a[7:0]] <= bus_b.mem_d;
        end
    end

    // ---------------- accessors ----------------
    function automatic logic get_ack(int d, int p);
        if (d == 0) return (p == 0) ? bus_a.ack0 : bus_a.ack1;
        return (p == 0) ? bus_b.ack0 : bus_b.ack1;
    endfunction

    function automatic logic [15:0] get_rdata(int d, int p);
        if (d == 0) return (p == 0) ? bus_a.rdata0 : bus_a.rdata1;
        return (p == 0) ? bus_b.rdata0 : bus_b.rdata1;
    endfunction

    function automatic logic [15:0] get_memw(int d);
        return (d == 0) ? bus_a.mem_w : bus_b.mem_w;
    endfunction

    function automatic logic [15:0] get_mema(int d);
        return (d == 0) ? bus_a.mem_a : bus_b.mem_a;
    endfunction

    function automatic logic [15:0] get_memd(int d);
        return (d == 0) ? bus_a.mem_d : bus_b.mem_d;
    endfunction

    function automatic logic get_busy(int d);
        return (d == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    function automatic int sb_size(int d);
        return (d == 0) ? sbq_a.size() : sbq_b.size();
    endfunction

    function automatic exp_t sb_pop(int d);
        if (d == 0) return sbq_a.pop_front();
        return sbq_b.pop_front();
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic set_req(int d, int p, logic req, logic we, logic [15:0] addr, logic [15:0] wdata);
        if (d == 0 && p == 0) begin
            bus_a.req0 = req; bus_a.we0 = we; bus_a.addr0 = addr; bus_a.wdata0 = wdata;
        end else if (d == 0) begin
            bus_a.req1 = req; bus_a.we1 = we; bus_a.addr1 = addr; bus_a.wdata1 = wdata;
        end else if (p == 0) begin
            bus_b.req0 = req; bus_b.we0 = we; bus_b.addr0 = addr; bus_b.wdata0 = wdata;
        end else begin
            bus_b.req1 = req; bus_b.we1 = we; bus_b.addr1 = addr; bus_b.wdata1 = wdata;
        end
    endtask

    // Queue the response the requester must eventually see.
    task automatic expect_ack(int d, int p, logic [15:0] data, int at_cyc);
        exp_t e;
        e.port = p; e.data = data; e.cyc = at_cyc;
        if (d == 0) sbq_a.push_back(e);
        else        sbq_b.push_back(e);
    endtask

    task automatic issue(int d, int p, logic we, logic [15:0] addr, logic [15:0] wdata,
                         logic [15:0] exp_rd, int at_cyc);
        expect_ack(d, p, exp_rd, at_cyc);
        set_req(d, p, 1'b1, we, addr, wdata);
    endtask

    // Returns #1 after the edge following the ack, i.e. in the requester's
    // "cycle after ack" where it may drop or replace its request.
    task automatic wait_ack(int d, int p);
        int n;
        bit seen;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (get_ack(d, p) === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL ack_timeout dut=%0d port=%0d: no ack within 40 cycles", d, p);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic chk_outs_zero(int d);
        chk($sformatf("rst_mem_w[%0d]", d),  32'(get_memw(d)), 32'd0);
        chk($sformatf("rst_mem_a[%0d]", d),  32'(get_mema(d)), 32'd0);
        chk($sformatf("rst_mem_d[%0d]", d),  32'(get_memd(d)), 32'd0);
        chk($sformatf("rst_ack0[%0d]", d),   32'(get_ack(d, 0)), 32'd0);
        chk($sformatf("rst_ack1[%0d]", d),   32'(get_ack(d, 1)), 32'd0);
        chk($sformatf("rst_rdata0[%0d]", d), 32'(get_rdata(d, 0)), 32'd0);
        chk($sformatf("rst_rdata1[%0d]", d), 32'(get_rdata(d, 1)), 32'd0);
        chk($sformatf("rst_busy[%0d]", d),   32'(get_busy(d)), 32'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            wrun[0] = 0;
            wrun[1] = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_a0 = get_ack(d, 0);
                m_a1 = get_ack(d, 1);
                if (m_a0 === 1'b1 || m_a1 === 1'b1) begin
                    if (sb_size(d) == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_ack dut=%0d: got ack0=%b ack1=%b, expected none (cycle %0d)",
                                 d, m_a0, m_a1, cyc);
                    end else begin
                        m_e = sb_pop(d);
                        chk($sformatf("ack_port[%0d]", d), {30'd0, m_a1, m_a0},
                            (m_e.port == 1) ? 32'd2 : 32'd1);
                        chk($sformatf("ack_rdata[%0d]p%0d", d, m_e.port),
                            32'(get_rdata(d, m_e.port)), 32'(m_e.data));
                        chk($sformatf("ack_cycle[%0d]", d), cyc, m_e.cyc);
                    end
                end
                if (get_memw(d) === MEM_WE_ON) begin
                    wrun[d]++;
                end else if (wrun[d] != 0) begin
                    chk($sformatf("memw_width[%0d]", d), wrun[d], (d == 0) ? AC_A : AC_B);
                    wrun[d] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        wrun[0] = 0; wrun[1] = 0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                set_req(d, p, 1'b0, 1'b0, 16'd0, 16'd0);

        // 1. Asynchronous reset between edges, then a quiet idle period.
        #12; rst_n = 1'b0;
        #1;
        chk_outs_zero(0);
        chk_outs_zero(1);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_quiet_a", {15'd0, get_busy(0), get_memw(0)}, 32'd0);
            chk("idle_quiet_b", {15'd0, get_busy(1), get_memw(1)}, 32'd0);
        end
        @(posedge clk); #1;

        // 2. Port 0 write a=4 d=6, then read it back; ack 2 cycles after issue.
        c = cyc; issue(0, 0, 1'b1, 16'd4, 16'd6, 16'd0, c + 2);
        wait_ack(0, 0);
        c = cyc; issue(0, 0, 1'b0, 16'd4, 16'd0, 16'd6, c + 2);
        wait_ack(0, 0);
        set_req(0, 0, 1'b0, 1'b0, 16'd0, 16'd0);

        // 3. Fresh reset, simultaneous write a=3 d=7 (p0) and read a=3 (p1).
        pulse_reset();
        c = cyc;
        issue(0, 0, 1'b1, 16'd3, 16'd7, 16'd0, c + 2);
        issue(0, 1, 1'b0, 16'd3, 16'd0, 16'd7, c + 5);
        wait_ack(0, 0); set_req(0, 0, 1'b0, 1'b0, 16'd0, 16'd0);
        wait_ack(0, 1); set_req(0, 1, 1'b0, 1'b0, 16'd0, 16'd0);

        // 4. Both ports keep reading (p0 a=0 -> 5, p1 a=8 -> 8): strict alternation.
        c = cyc;
        for (int k = 0; k < 6; k++)
            expect_ack(0, k % 2, (k % 2) ? 16'd8 : 16'd5, c + 2 + 3 * k);
        set_req(0, 0, 1'b1, 1'b0, 16'd0, 16'd0);
        set_req(0, 1, 1'b1, 1'b0, 16'd8, 16'd0);
        repeat (3) wait_ack(0, 0);
        set_req(0, 0, 1'b0, 1'b0, 16'd0, 16'd0);
        wait_ack(0, 1);
        set_req(0, 1, 1'b0, 1'b0, 16'd0, 16'd0);

        // Leave port 0 as the last grant so a reset must restore port 0 priority.
        c = cyc; issue(0, 0, 1'b0, 16'd0, 16'd0, 16'd5, c + 2);
        wait_ack(0, 0); set_req(0, 0, 1'b0, 1'b0, 16'd0, 16'd0);

        // 6. Reset during the ACCESS of a write a=5 d=9: no ack, mem_w drops at once.
        set_req(0, 0, 1'b1, 1'b1, 16'd5, 16'd9);
        @(posedge clk); @(negedge clk);
        chk("t6_access_memw", 32'(get_memw(0)), 32'(MEM_WE_ON));
        #1; rst_n = 1'b0;
        #1;
        chk("t6_rst_memw", 32'(get_memw(0)), 32'd0);
        chk("t6_rst_busy", 32'(get_busy(0)), 32'd0);
        chk("t6_rst_ack0", 32'(get_ack(0, 0)), 32'd0);
        set_req(0, 0, 1'b0, 1'b0, 16'd0, 16'd0);
        @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        c = cyc;
        issue(0, 0, 1'b0, 16'd8, 16'd0, 16'd8, c + 2);
        issue(0, 1, 1'b0, 16'd0, 16'd0, 16'd5, c + 5);
        wait_ack(0, 0); set_req(0, 0, 1'b0, 1'b0, 16'd0, 16'd0);
        wait_ack(0, 1); set_req(0, 1, 1'b0, 1'b0, 16'd0, 16'd0);

        // 5. ACCESS_CYCLES=3: read latency 4, write held 3 cycles, inputs ignored mid-access.
        c = cyc; issue(1, 0, 1'b0, 16'd8, 16'd0, 16'd8, c + 4);
        wait_ack(1, 0); set_req(1, 0, 1'b0, 1'b0, 16'd0, 16'd0);
        c = cyc; issue(1, 1, 1'b1, 16'd2, 16'h1234, 16'd0, c + 4);
        @(posedge clk); #1;
        set_req(1, 1, 1'b1, 1'b1, 16'h0077, 16'hFFFF);
        repeat (2) begin
            @(negedge clk);
            chk("t5_mem_a_latched", 32'(get_mema(1)), 32'd2);
            chk("t5_mem_d_latched", 32'(get_memd(1)), 32'h1234);
            chk("t5_busy", 32'(get_busy(1)), 32'd1);
        end
        wait_ack(1, 1); set_req(1, 1, 1'b0, 1'b0, 16'd0, 16'd0);
        c = cyc; issue(1, 0, 1'b0, 16'd2, 16'd0, 16'h1234, c + 4);
        wait_ack(1, 0); set_req(1, 0, 1'b0, 1'b0, 16'd0, 16'd0);

        repeat (4) @(posedge clk);
        chk("sb_drained_a", sb_size(0), 32'd0);
        chk("sb_drained_b", sb_size(1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
